lr_parser_core: RTL and testbench

//  Parametrised table-driven LR(1) parser engine: consumes tokens over a valid/ready handshake,

---
 rtl/lr_parser_pkg.sv | 39 +++
 rtl/lr_stack.sv | 60 ++++++
 rtl/lr_parser_core.sv | 233 +++++++++++++++++++++++
 tb/tb_lr_parser_core.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lr_parser_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : lr_parser_pkg
//  Description : Shared encodings for the table-driven LR(1) parser engine:
//                ACTION opcodes, error codes, table selectors, FSM states.
//  Revision    : 1.0 - initial release
// ============================================================================
package lr_parser_pkg;

    // ACTION table opcodes, stored in TBL_WDATA[9:8]
    localparam logic [1:0] ACT_ERROR     = 2'd0;
    localparam logic [1:0] ACT_SHIFT     = 2'd1;
    localparam logic [1:0] ACT_REDUCE    = 2'd2;
    localparam logic [1:0] ACT_ACCEPT    = 2'd3;

    // Sticky error codes reported on ERR_CODE
    localparam logic [1:0] ERR_NONE      = 2'd0;
    localparam logic [1:0] ERR_SYNTAX    = 2'd1;
    localparam logic [1:0] ERR_OVERFLOW  = 2'd2;
    localparam logic [1:0] ERR_UNDERFLOW = 2'd3;

    // Table selector for runtime table writes
    localparam logic [1:0] TBL_SEL_ACTION = 2'd0;
    localparam logic [1:0] TBL_SEL_GOTO   = 2'd1;
    localparam logic [1:0] TBL_SEL_LEN    = 2'd2;

    // Parser control states
    typedef enum logic [2:0] {
        S_WAIT   = 3'd0,
        S_MOVE   = 3'd1,
        S_POP    = 3'd2,
        S_GOTO   = 3'd3,
        S_EMIT   = 3'd4,
        S_ACCEPT = 3'd5,
        S_ERROR  = 3'd6
    } state_t;

endpackage
`default_nettype wire

// File: rtl/lr_stack.sv
`default_nettype none
// ============================================================================
//  Module      : lr_stack
//  Description : State stack for the LR parser. Holds the base state 0
//                implicitly, so the stack is never truly empty; o_empty means
//                only the base entry remains. Push and pop in the same cycle
//                are never requested by the parser.
//  Revision    : 1.0 - initial release
// ============================================================================
module lr_stack #(
    parameter  int W     = 6,
    parameter  int DEPTH = 1024,
    localparam int SP_W  = $clog2(DEPTH + 1),
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic            CLK,
    input  logic            RST_N,
    input  logic            i_clear,
    input  logic            i_push,
    input  logic            i_pop,
    input  logic [W-1:0]    i_data,
    output logic [W-1:0]    o_top,
    output logic [SP_W-1:0] o_sp,
    output logic            o_full,
    output logic            o_empty
);

    logic [W-1:0]    r_mem [0:DEPTH-1];
    logic [SP_W-1:0] r_sp;
    logic [AW-1:0]   w_push_idx;
    logic [AW-1:0]   w_top_idx;

    assign w_push_idx = AW'(r_sp);
    assign w_top_idx  = AW'(r_sp - SP_W'(1));

    // Stack pointer: clear/reset restores the single base entry
    always_ff @(posedge CLK) begin
        if (!RST_N || i_clear) begin
            r_sp <= SP_W'(1);
        end else if (i_push) begin
            r_sp <= r_sp + SP_W'(1);
        end else if (i_pop) begin
            r_sp <= r_sp - SP_W'(1);
        end
    end

    // Storage array; entry 0 is never read, the base state is synthesised below
    always_ff @(posedge CLK) begin
        if (RST_N && !i_clear && i_push) begin
            r_mem[w_push_idx] <= i_data;
        end
    end

    assign o_top   = (r_sp == SP_W'(1)) ? '0 : r_mem[w_top_idx];
    assign o_sp    = r_sp;
    assign o_full  = (r_sp == SP_W'(DEPTH));
    assign o_empty = (r_sp == SP_W'(1));

endmodule
`default_nettype wire

// File: rtl/lr_parser_core.sv
`default_nettype none
// ============================================================================
//  Module      : lr_parser_core
//  Description : Table-driven LR(1) parser engine. Accepts tokens over a
//                valid/ready handshake, walks runtime-loadable ACTION / GOTO /
//                LEN tables and emits one rule ID per reduction with output
//                back-pressure. Detects syntax errors and stack over/underflow.
//  Revision    : 1.0 - initial release
// ============================================================================
module lr_parser_core
    import lr_parser_pkg::*;
#(
    parameter  int N_STATES = 43,
    parameter  int N_TOKENS = 16,
    parameter  int N_RULES  = 16,
    parameter  int TOK_W    = 16,
    parameter  int DEPTH    = 1024,
    parameter  int LEN_W    = 4,
    localparam int STATE_W  = $clog2(N_STATES),
    localparam int TK_W     = $clog2(N_TOKENS),
    localparam int RL_W     = $clog2(N_RULES),
    localparam int SP_W     = $clog2(DEPTH + 1)
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             CLEAR,
    input  logic             TBL_WE,
    input  logic [1:0]       TBL_SEL,
    input  logic [15:0]      TBL_ADDR,
    input  logic [9:0]       TBL_WDATA,
    input  logic             I_VALID,
    output logic             I_READY,
    input  logic [TOK_W-1:0] I_TOKEN,
    output logic             O_VALID,
    input  logic             O_READY,
    output logic [RL_W-1:0]  O_RULE,
    output logic [2:0]       STAT,
    output logic [1:0]       ERR_CODE,
    output logic [SP_W-1:0]  SP
);

    localparam int ACT_AW    = STATE_W + TK_W;
    localparam int GOTO_AW   = STATE_W + RL_W;
    localparam int ACT_SIZE  = N_STATES * N_TOKENS;
    localparam int GOTO_SIZE = N_STATES * N_RULES;

    // Runtime-loadable tables (plain RAM, never cleared)
    logic [9:0]       r_act_mem  [0:ACT_SIZE-1];
    logic [7:0]       r_goto_mem [0:GOTO_SIZE-1];
    logic [LEN_W-1:0] r_len_mem  [0:N_RULES-1];

    state_t           r_state;
    logic [7:0]       r_kind;
    logic [RL_W-1:0]  r_rule;
    logic [LEN_W-1:0] r_cnt;
    logic             r_o_valid;
    logic [RL_W-1:0]  r_o_rule;
    logic [1:0]       r_err;

    logic [STATE_W-1:0] w_top;
    logic [SP_W-1:0]    w_sp;
    logic               w_full;
    logic               w_empty;
    logic               w_push;
    logic               w_pop;
    logic [STATE_W-1:0] w_push_data;

    logic               w_tbl_open;
    logic [ACT_AW-1:0]  w_act_idx;
    logic [GOTO_AW-1:0] w_goto_idx;
    logic [9:0]         w_act_word;
    logic [1:0]         w_act;
    logic [7:0]         w_val;
    logic [RL_W-1:0]    w_act_rule;
    logic [LEN_W-1:0]   w_len;
    logic [7:0]         w_goto_val;
    logic               w_kind_ok;
    logic               w_unused_payload;

    // Token payload bits carry no meaning for the parser
    assign w_unused_payload = &{1'b0, I_TOKEN[TOK_W-9:0]};

    // Tables may only change while the engine is idle or stopped
    assign w_tbl_open = (r_state == S_WAIT) || (r_state == S_ACCEPT) || (r_state == S_ERROR);

    // Table write port; out-of-range addresses are dropped
    always_ff @(posedge CLK) begin
        if (TBL_WE && w_tbl_open) begin
            case (TBL_SEL)
                TBL_SEL_ACTION: if (int'(TBL_ADDR) < ACT_SIZE)
                                    r_act_mem[ACT_AW'(TBL_ADDR)] <= TBL_WDATA;
                TBL_SEL_GOTO:   if (int'(TBL_ADDR) < GOTO_SIZE)
                                    r_goto_mem[GOTO_AW'(TBL_ADDR)] <= TBL_WDATA[7:0];
                TBL_SEL_LEN:    if (int'(TBL_ADDR) < N_RULES)
                                    r_len_mem[RL_W'(TBL_ADDR)] <= TBL_WDATA[LEN_W-1:0];
                default: ;
            endcase
        end
    end

    // Combinational table reads; out-of-range indices read as ERROR / 0
    assign w_kind_ok  = int'(r_kind) < N_TOKENS;
    assign w_act_idx  = {w_top, r_kind[TK_W-1:0]};
    assign w_act_word = (int'(w_act_idx) < ACT_SIZE) ? r_act_mem[w_act_idx] : '0;
    assign w_act      = w_act_word[9:8];
    assign w_val      = w_act_word[7:0];
    assign w_act_rule = RL_W'(w_val);
    assign w_len      = r_len_mem[w_act_rule];
    assign w_goto_idx = {w_top, r_rule};
    assign w_goto_val = (int'(w_goto_idx) < GOTO_SIZE) ? r_goto_mem[w_goto_idx] : '0;

    // Stack push/pop requests decoded from the current state and table lookups
    always_comb begin
        w_push      = 1'b0;
        w_pop       = 1'b0;
        w_push_data = '0;
        if (RST_N && !CLEAR) begin
            case (r_state)
                S_MOVE: if (w_kind_ok && (w_act == ACT_SHIFT) && !w_full) begin
                    w_push      = 1'b1;
                    w_push_data = STATE_W'(w_val);
                end
                S_POP:  if ((r_cnt != '0) && !w_empty) begin
                    w_pop = 1'b1;
                end
                S_GOTO: begin
                    w_push      = 1'b1;
                    w_push_data = STATE_W'(w_goto_val);
                end
                default: ;
            endcase
        end
    end

    lr_stack #(
        .W     (STATE_W),
        .DEPTH (DEPTH)
    ) u_stack (
        .CLK     (CLK),
        .RST_N   (RST_N),
        .i_clear (CLEAR),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_data  (w_push_data),
        .o_top   (w_top),
        .o_sp    (w_sp),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // Parser control FSM; CLEAR behaves as reset but leaves the tables alone
    always_ff @(posedge CLK) begin
        if (!RST_N || CLEAR) begin
            r_state   <= S_WAIT;
            r_kind    <= '0;
            r_rule    <= '0;
            r_cnt     <= '0;
            r_o_valid <= 1'b0;
            r_o_rule  <= '0;
            r_err     <= ERR_NONE;
        end else begin
            case (r_state)
                S_WAIT: begin
                    if (I_VALID) begin
                        r_kind  <= I_TOKEN[TOK_W-1 -: 8];
                        r_state <= S_MOVE;
                    end
                end
                S_MOVE: begin
                    if (!w_kind_ok) begin
                        r_err   <= ERR_SYNTAX;
                        r_state <= S_ERROR;
                    end else begin
                        case (w_act)
                            ACT_SHIFT: begin
                                if (w_full) begin
                                    r_err   <= ERR_OVERFLOW;
                                    r_state <= S_ERROR;
                                end else begin
                                    r_state <= S_WAIT;
                                end
                            end
                            ACT_REDUCE: begin
                                r_rule  <= w_act_rule;
                                r_cnt   <= w_len;
                                r_state <= S_POP;
                            end
                            ACT_ACCEPT: r_state <= S_ACCEPT;
                            default: begin
                                r_err   <= ERR_SYNTAX;
                                r_state <= S_ERROR;
                            end
                        endcase
                    end
                end
                S_POP: begin
                    if (r_cnt == '0) begin
                        r_state <= S_GOTO;
                    end else if (w_empty) begin
                        r_err   <= ERR_UNDERFLOW;
                        r_state <= S_ERROR;
                    end else begin
                        r_cnt <= r_cnt - LEN_W'(1);
                    end
                end
                S_GOTO: begin
                    r_o_valid <= 1'b1;
                    r_o_rule  <= r_rule;
                    r_state   <= S_EMIT;
                end
                S_EMIT: begin
                    // Same latched token is re-examined after the reduction
                    if (O_READY) begin
                        r_o_valid <= 1'b0;
                        r_state   <= S_MOVE;
                    end
                end
                S_ACCEPT: r_state <= S_ACCEPT;
                S_ERROR:  r_state <= S_ERROR;
                default:  r_state <= S_WAIT;
            endcase
        end
    end

    assign I_READY  = (r_state == S_WAIT);
    assign STAT     = {r_state == S_WAIT, r_state == S_ACCEPT, r_state == S_ERROR};
    assign O_VALID  = r_o_valid;
    assign O_RULE   = r_o_rule;
    assign ERR_CODE = r_err;
    assign SP       = w_sp;

endmodule
`default_nettype wire

// File: tb/tb_lr_parser_core.sv
`default_nettype none
// ============================================================================
//  Module      : tb_lr_parser_core
//  Description : Directed scoreboard bench for lr_parser_core using the
//                E->E+T | E->T | T->id grammar plus small extra tables for
//                overflow, underflow and back-pressure corner cases.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_lr_parser_core;

    localparam int DEPTH = 4;
    localparam int SP_W  = 3;

    // token kinds
    localparam int K_END  = 0;
    localparam int K_ID   = 1;
    localparam int K_PLUS = 2;

    logic            CLK = 1'b0;
    logic            RST_N;
    logic            CLEAR;
    logic            TBL_WE;
    logic [1:0]      TBL_SEL;
    logic [15:0]     TBL_ADDR;
    logic [9:0]      TBL_WDATA;
    logic            I_VALID;
    logic            I_READY;
    logic [15:0]     I_TOKEN;
    logic            O_VALID;
    logic            O_READY;
    logic [3:0]      O_RULE;
    logic [2:0]      STAT;
    logic [1:0]      ERR_CODE;
    logic [SP_W-1:0] SP;

    int n_checks = 0;
    int n_pass   = 0;
    int exp_q[$];

    always #5 CLK = ~CLK;

    lr_parser_core #(
        .N_STATES (43),
        .N_TOKENS (16),
        .N_RULES  (16),
        .TOK_W    (16),
        .DEPTH    (DEPTH),
        .LEN_W    (4)
    ) dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .CLEAR     (CLEAR),
        .TBL_WE    (TBL_WE),
        .TBL_SEL   (TBL_SEL),
        .TBL_ADDR  (TBL_ADDR),
        .TBL_WDATA (TBL_WDATA),
        .I_VALID   (I_VALID),
        .I_READY   (I_READY),
        .I_TOKEN   (I_TOKEN),
        .O_VALID   (O_VALID),
        .O_READY   (O_READY),
        .O_RULE    (O_RULE),
        .STAT      (STAT),
        .ERR_CODE  (ERR_CODE),
        .SP        (SP)
    );

    function automatic void chk(string nm, int act, int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endfunction

    function automatic int aaddr(int s, int k);
        return s * 16 + k;
    endfunction

    function automatic int aword(int a, int v);
        return a * 256 + v;
    endfunction

    // Scoreboard monitor: every accepted rule must match the next expected one
    always @(negedge CLK) begin
        if (RST_N && O_VALID && O_READY) begin
            if (exp_q.size() == 0) chk("rule_unexpected", int'(O_RULE), -1);
            else                   chk("rule_order", int'(O_RULE), exp_q.pop_front());
        end
    end

    task automatic tbl_write(input logic [1:0] sel, input int addr, input int data);
        @(negedge CLK);
        TBL_WE    = 1'b1;
        TBL_SEL   = sel;
        TBL_ADDR  = 16'(addr);
        TBL_WDATA = 10'(data);
        @(negedge CLK);
        TBL_WE    = 1'b0;
    endtask

    task automatic send(input int kind);
        int i;
        i = 0;
        @(negedge CLK);
        while (!I_READY && i < 200) begin
            @(negedge CLK);
            i++;
        end
        chk("send_ready", int'(I_READY), 1);
        I_VALID = 1'b1;
        I_TOKEN = {8'(kind), 8'hA5};
        @(posedge CLK);
        #1 I_VALID = 1'b0;
    endtask

    task automatic wait_stat(input logic [2:0] e, input string nm);
        int i;
        i = 0;
        while (STAT !== e && i < 300) begin
            @(negedge CLK);
            i++;
        end
        chk(nm, int'(STAT), int'(e));
    endtask

    task automatic wait_drain(input string nm);
        int i;
        i = 0;
        while (exp_q.size() != 0 && i < 300) begin
            @(negedge CLK);
            i++;
        end
        chk(nm, exp_q.size(), 0);
    endtask

    task automatic do_clear();
        @(negedge CLK);
        CLEAR = 1'b1;
        @(negedge CLK);
        CLEAR = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        RST_N = 1'b0; CLEAR = 1'b0; TBL_WE = 1'b0; TBL_SEL = '0;
        TBL_ADDR = '0; TBL_WDATA = '0; I_VALID = 1'b0; I_TOKEN = '0;
        O_READY = 1'b1;
        repeat (3) @(negedge CLK);
        RST_N = 1'b1;

        chk("reset_stat",   int'(STAT), 4);
        chk("reset_sp",     int'(SP), 1);
        chk("reset_iready", int'(I_READY), 1);
        chk("reset_ovalid", int'(O_VALID), 0);
        chk("reset_orule",  int'(O_RULE), 0);
        chk("reset_err",    int'(ERR_CODE), 0);

        // expression grammar: r0 E->E+T, r1 E->T, r2 T->id
        tbl_write(0, aaddr(0, K_ID),   aword(1, 3));
        tbl_write(0, aaddr(1, K_END),  aword(3, 0));
        tbl_write(0, aaddr(1, K_PLUS), aword(1, 4));
        tbl_write(0, aaddr(2, K_END),  aword(2, 1));
        tbl_write(0, aaddr(2, K_PLUS), aword(2, 1));
        tbl_write(0, aaddr(3, K_END),  aword(2, 2));
        tbl_write(0, aaddr(3, K_PLUS), aword(2, 2));
        tbl_write(0, aaddr(4, K_ID),   aword(1, 3));
        tbl_write(0, aaddr(5, K_END),  aword(2, 0));
        tbl_write(0, aaddr(5, K_PLUS), aword(2, 0));
        tbl_write(1, aaddr(0, 0), 1);
        tbl_write(1, aaddr(0, 1), 1);
        tbl_write(1, aaddr(0, 2), 2);
        tbl_write(1, aaddr(4, 2), 5);
        tbl_write(2, 0, 3);
        tbl_write(2, 1, 1);
        tbl_write(2, 2, 1);
        // shift-only chain on kind 5
        tbl_write(0, aaddr(0, 5),  aword(1, 10));
        tbl_write(0, aaddr(10, 5), aword(1, 11));
        tbl_write(0, aaddr(11, 5), aword(1, 12));
        tbl_write(0, aaddr(12, 5), aword(1, 13));
        tbl_write(0, aaddr(13, 5), aword(1, 14));
        // underflow path: shift 6, shift 6, reduce r3 (LEN 5) on kind 7
        tbl_write(0, aaddr(0, 6),  aword(1, 20));
        tbl_write(0, aaddr(20, 6), aword(1, 21));
        tbl_write(0, aaddr(21, 7), aword(2, 3));
        tbl_write(2, 3, 5);

        // id + id $
        exp_q.push_back(2); exp_q.push_back(1); exp_q.push_back(2); exp_q.push_back(0);
        send(K_ID); send(K_PLUS); send(K_ID); send(K_END);
        wait_stat(3'b010, "expr_accept_stat");
        chk("expr_accept_sp",     int'(SP), 2);
        chk("expr_accept_err",    int'(ERR_CODE), 0);
        chk("expr_accept_iready", int'(I_READY), 0);
        wait_drain("expr_drain");

        // syntax error on leading '+'
        do_clear();
        chk("clear_stat", int'(STAT), 4);
        chk("clear_sp",   int'(SP), 1);
        send(K_PLUS);
        wait_stat(3'b001, "syntax_stat");
        chk("syntax_err", int'(ERR_CODE), 1);
        repeat (3) @(negedge CLK);
        chk("syntax_iready_sticky", int'(I_READY), 0);
        chk("syntax_stat_sticky",   int'(STAT), 1);

        // kind beyond N_TOKENS
        do_clear();
        send(16);
        wait_stat(3'b001, "badkind_stat");
        chk("badkind_err", int'(ERR_CODE), 1);

        // overflow: 4th shift with DEPTH=4
        do_clear();
        send(5); send(5); send(5); send(5);
        wait_stat(3'b001, "overflow_stat");
        chk("overflow_err", int'(ERR_CODE), 2);
        chk("overflow_sp",  int'(SP), 4);

        // back-pressure on first reduce
        do_clear();
        @(posedge CLK); #2 O_READY = 1'b0;
        exp_q.push_back(2); exp_q.push_back(1);
        send(K_ID); send(K_PLUS);
        begin
            int i;
            i = 0;
            while (!O_VALID && i < 100) begin
                @(negedge CLK);
                i++;
            end
        end
        for (int c = 0; c < 10; c++) begin
            @(negedge CLK);
            chk("hold_ovalid", int'(O_VALID), 1);
            chk("hold_orule",  int'(O_RULE), 2);
            chk("hold_iready", int'(I_READY), 0);
            chk("hold_sp",     int'(SP), 2);
        end
        @(posedge CLK); #2 O_READY = 1'b1;
        wait_stat(3'b100, "hold_resume_wait");
        chk("hold_resume_sp", int'(SP), 3);
        exp_q.push_back(2); exp_q.push_back(0);
        send(K_ID); send(K_END);
        wait_stat(3'b010, "hold_accept_stat");
        chk("hold_accept_sp", int'(SP), 2);
        wait_drain("hold_drain");

        // underflow: LEN 5 reduce with SP=3
        do_clear();
        send(6); send(6); send(7);
        wait_stat(3'b001, "underflow_stat");
        chk("underflow_err", int'(ERR_CODE), 3);
        chk("underflow_sp",  int'(SP), 1);
        do_clear();
        chk("uclear_sp",   int'(SP), 1);
        chk("uclear_stat", int'(STAT), 4);
        chk("uclear_err",  int'(ERR_CODE), 0);

        // table write while popping must be ignored
        exp_q.push_back(2); exp_q.push_back(1);
        send(K_ID); send(K_END);
        @(posedge CLK);
        @(negedge CLK);
        TBL_WE = 1'b1; TBL_SEL = 2'd0; TBL_ADDR = 16'(aaddr(1, K_END)); TBL_WDATA = 10'd0;
        @(posedge CLK);
        @(posedge CLK);
        @(negedge CLK);
        TBL_WE = 1'b0;
        wait_stat(3'b010, "popwrite_ignored_stat");
        wait_drain("popwrite_drain");

        // same write while waiting takes effect
        do_clear();
        tbl_write(0, aaddr(1, K_END), 0);
        exp_q.push_back(2); exp_q.push_back(1);
        send(K_ID); send(K_END);
        wait_stat(3'b001, "waitwrite_applied_stat");
        chk("waitwrite_err", int'(ERR_CODE), 1);
        chk("waitwrite_sp",  int'(SP), 2);
        wait_drain("waitwrite_drain");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
